// File: rtl/otp_session_ctrl.sv
// rtl/otp_session_ctrl.sv - round-robin encrypt/decrypt scheduler and pad-slot tracker for the OTP engine
// Define OTP_STATS_EN to add saturating stat_enc/stat_dec/stat_err result counters.
module otp_session_ctrl #(
   parameter int SLOTS  = 8,
   parameter int IDX_W  = 3,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enc_valid,
   output logic              enc_ready,
   input  logic [DATA_W-1:0] enc_data,
   input  logic              dec_valid,
   output logic              dec_ready,
   input  logic [DATA_W-1:0] dec_data,
   input  logic [IDX_W-1:0]  dec_idx,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [IDX_W-1:0]  res_idx,
   output logic              res_is_dec,
   output logic              res_err,
   output logic              full,
   output logic              eng_ena,
   output logic              eng_decrypt,
   output logic [DATA_W-1:0] eng_data,
   output logic [IDX_W-1:0]  eng_rnum,
   input  logic [DATA_W-1:0] eng_out,
   input  logic [IDX_W-1:0]  eng_index
`ifdef OTP_STATS_EN
   ,
   output logic [7:0]        stat_enc,
   output logic [7:0]        stat_dec,
   output logic [7:0]        stat_err
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

   state_t             state_q, state_d;
   logic [SLOTS-1:0]   slot_used_q, slot_used_d;
   logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic               rr_last_q, rr_last_d;   // 1 = last grant went to decrypt
   logic               op_q, op_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]  res_data_q, res_data_d;
   logic [IDX_W-1:0]   res_idx_q, res_idx_d;
   logic               res_is_dec_q, res_is_dec_d;
   logic               res_err_q, res_err_d;
   logic               full_q;
   logic               enc_elig, grant_enc, grant_dec;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         slot_used_q  <= '0;
         wr_ptr_q     <= '0;
         rr_last_q    <= 1'b1;
         op_q         <= 1'b0;
         data_q       <= '0;
         idx_q        <= '0;
         res_data_q   <= '0;
         res_idx_q    <= '0;
         res_is_dec_q <= 1'b0;
         res_err_q    <= 1'b0;
         full_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_used_q  <= slot_used_d;
         wr_ptr_q     <= wr_ptr_d;
         rr_last_q    <= rr_last_d;
         op_q         <= op_d;
         data_q       <= data_d;
         idx_q        <= idx_d;
         res_data_q   <= res_data_d;
         res_idx_q    <= res_idx_d;
         res_is_dec_q <= res_is_dec_d;
         res_err_q    <= res_err_d;
         full_q       <= &slot_used_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      slot_used_d  = slot_used_q;
      wr_ptr_d     = wr_ptr_q;
      rr_last_d    = rr_last_q;
      op_d         = op_q;
      data_d       = data_q;
      idx_d        = idx_q;
      res_data_d   = res_data_q;
      res_idx_d    = res_idx_q;
      res_is_dec_d = res_is_dec_q;
      res_err_d    = res_err_q;
      enc_ready    = 1'b0;
      dec_ready    = 1'b0;
      eng_ena      = 1'b0;
      eng_decrypt  = 1'b0;
      eng_data     = '0;
      eng_rnum     = '0;
      enc_elig     = enc_valid & ~slot_used_q[wr_ptr_q];
      grant_enc    = 1'b0;
      grant_dec    = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A blocked encrypt is not eligible, so decrypt wins regardless of rr_last
            grant_enc = enc_elig & (~dec_valid | rr_last_q);
            grant_dec = dec_valid & ~grant_enc;
            enc_ready = grant_enc;
            dec_ready = grant_dec;
            if (grant_enc) begin
               op_d      = 1'b0;
               data_d    = enc_data;
               rr_last_d = 1'b0;
               state_d   = S_ISSUE;
            end else if (grant_dec) begin
               op_d      = 1'b1;
               data_d    = dec_data;
               idx_d     = dec_idx;
               rr_last_d = 1'b1;
               if (!slot_used_q[dec_idx]) begin
                  res_data_d   = '0;
                  res_idx_d    = dec_idx;
                  res_is_dec_d = 1'b1;
                  res_err_d    = 1'b1;
                  state_d      = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            eng_ena     = 1'b1;
            eng_decrypt = op_q;
            eng_data    = data_q;
            eng_rnum    = idx_q;
            state_d     = S_CAPTURE;
         end
         S_CAPTURE: begin
            res_data_d   = eng_out;
            res_is_dec_d = op_q;
            if (!op_q) begin
               res_idx_d             = wr_ptr_q;
               res_err_d             = (eng_index != wr_ptr_q);
               slot_used_d[wr_ptr_q] = 1'b1;
               wr_ptr_d              = wr_ptr_q + 1'b1;
            end else begin
               res_idx_d          = idx_q;
               res_err_d          = 1'b0;
               slot_used_d[idx_q] = 1'b0;
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign res_valid  = (state_q == S_RESP);
   assign res_data   = res_data_q;
   assign res_idx    = res_idx_q;
   assign res_is_dec = res_is_dec_q;
   assign res_err    = res_err_q;
   assign full       = full_q;

`ifdef OTP_STATS_EN
   logic [7:0] stat_enc_q, stat_dec_q, stat_err_q;
   logic       res_fire;

   assign res_fire = res_valid & res_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_enc_q <= '0;
         stat_dec_q <= '0;
         stat_err_q <= '0;
      end else if (res_fire) begin
         if (res_err_q) begin
            if (stat_err_q != 8'hFF) stat_err_q <= stat_err_q + 8'd1;
         end else if (res_is_dec_q) begin
            if (stat_dec_q != 8'hFF) stat_dec_q <= stat_dec_q + 8'd1;
         end else begin
            if (stat_enc_q != 8'hFF) stat_enc_q <= stat_enc_q + 8'd1;
         end
      end
   end

   assign stat_enc = stat_enc_q;
   assign stat_dec = stat_dec_q;
   assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_otp_session_ctrl.sv
// tb/tb_otp_session_ctrl.sv - randomized bench for otp_session_ctrl against a transaction-level model
module tb_otp_session_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enc_valid = 1'b0, dec_valid = 1'b0, res_ready = 1'b1;
   logic [7:0] enc_data = '0, dec_data = '0;
   logic [2:0] dec_idx = '0;
   logic       enc_ready, dec_ready, res_valid, res_is_dec, res_err, full;
   logic [7:0] res_data;
   logic [2:0] res_idx;
   logic       eng_ena, eng_decrypt;
   logic [7:0] eng_data, eng_out;
   logic [2:0] eng_rnum, eng_index;
`ifdef OTP_STATS_EN
   logic [7:0] stat_enc, stat_dec, stat_err;
`endif

   otp_session_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_data(enc_data),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_data(dec_data), .dec_idx(dec_idx),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
      .res_is_dec(res_is_dec), .res_err(res_err), .full(full),
      .eng_ena(eng_ena), .eng_decrypt(eng_decrypt), .eng_data(eng_data), .eng_rnum(eng_rnum),
      .eng_out(eng_out), .eng_index(eng_index)
`ifdef OTP_STATS_EN
      , .stat_enc(stat_enc), .stat_dec(stat_dec), .stat_err(stat_err)
`endif
   );

   always #5 clk = ~clk;

   // Engine stand-in: registered XOR with a pad store and its own free-running write count
   logic [7:0] e_store [8];
   logic [2:0] e_cnt;
   logic [7:0] next_pad = '0;
   bit         idx_fault = 1'b0;
   int         ena_cnt = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         e_cnt     <= '0;
         eng_out   <= '0;
         eng_index <= '0;
      end else if (eng_ena) begin
         ena_cnt <= ena_cnt + 1;
         if (!eng_decrypt) begin
            e_store[e_cnt] <= next_pad;
            eng_out        <= eng_data ^ next_pad;
            eng_index      <= idx_fault ? e_cnt + 3'd1 : e_cnt;
            e_cnt          <= e_cnt + 3'd1;
         end else begin
            eng_out <= eng_data ^ e_store[eng_rnum];
         end
      end
   end

   // Reference model state
   logic [7:0] m_used;
   logic [7:0] m_pad [8];
   int         m_wr;
   bit         m_rr_dec;
   int         m_se, m_sd, m_sx;
   int         n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic model_reset();
      m_used = '0; m_wr = 0; m_rr_dec = 1'b1;
      m_se = 0; m_sd = 0; m_sx = 0;
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_res"}, {res_valid, res_data, res_idx, res_is_dec, res_err}, 0);
      check({tag, "_eng"}, {eng_ena, eng_decrypt, eng_data, eng_rnum}, 0);
      check({tag, "_rdy_full"}, {enc_ready, dec_ready, full}, 0);
   endtask

   task automatic do_reset();
      enc_valid = 0; dec_valid = 0; res_ready = 1;
      @(negedge clk); rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_zero("reset");
      rst_n = 1;
      model_reset();
   endtask

   task automatic run_req(input bit ev, input logic [7:0] ed, input bit dv,
                          input logic [7:0] dd, input logic [2:0] di, input int stall);
      int exp_g, got, n, ena0, exp_lat;
      logic [7:0] exp_data;
      logic [2:0] exp_idx;
      bit exp_dec, exp_err;
      logic [19:0] held;
      if (ev && !m_used[m_wr] && (!dv || m_rr_dec)) exp_g = 1;
      else if (dv) exp_g = 2;
      else exp_g = 0;
      @(negedge clk);
      next_pad = 8'($urandom);
      enc_valid = ev; enc_data = ed; dec_valid = dv; dec_data = dd; dec_idx = di;
      #1;
      got = enc_ready ? 1 : (dec_ready ? 2 : 0);
      check("grant", got, exp_g);
      if (exp_g == 0) begin
         repeat (3) begin
            @(negedge clk); #1;
            check("blocked_ready", {enc_ready, dec_ready}, 0);
         end
         enc_valid = 0; dec_valid = 0;
         return;
      end
      exp_lat = 3;
      if (exp_g == 1) begin
         exp_dec = 0; exp_idx = 3'(m_wr); exp_data = ed ^ next_pad; exp_err = idx_fault;
         m_used[m_wr] = 1'b1; m_pad[m_wr] = next_pad; m_wr = (m_wr + 1) % 8; m_rr_dec = 0;
      end else begin
         exp_dec = 1; exp_idx = di; m_rr_dec = 1;
         if (m_used[di]) begin
            exp_data = dd ^ m_pad[di]; exp_err = 0; m_used[di] = 1'b0;
         end else begin
            exp_data = 0; exp_err = 1; exp_lat = 1;
         end
      end
      ena0 = ena_cnt;
      @(posedge clk); #1;
      enc_valid = 0; dec_valid = 0;
      n = 1;
      while (!res_valid && n < 10) begin
         @(posedge clk); #1; n++;
      end
      check("latency", n, exp_lat);
      check("res_data", res_data, exp_data);
      check("res_idx_dec_err", {res_idx, res_is_dec, res_err}, {exp_idx, exp_dec, exp_err});
      check("eng_quiet", {eng_ena, eng_data}, 0);
      if (exp_lat == 1) check("no_engine", ena_cnt - ena0, 0);
      if (stall > 0) begin
         res_ready = 0; enc_valid = 1; dec_valid = 1;
         held = {res_valid, res_data, res_idx, res_is_dec, res_err};
         repeat (stall) begin
            @(posedge clk); #1;
            check("stall_hold", {res_valid, res_data, res_idx, res_is_dec, res_err}, held);
            check("stall_ready", {enc_ready, dec_ready}, 0);
         end
         enc_valid = 0; dec_valid = 0; res_ready = 1;
      end
      @(posedge clk); #1;
      check("full", full, &m_used);
      if (exp_err) m_sx = (m_sx < 255) ? m_sx + 1 : 255;
      else if (exp_dec) m_sd = (m_sd < 255) ? m_sd + 1 : 255;
      else m_se = (m_se < 255) ? m_se + 1 : 255;
   endtask

   initial begin
      logic [7:0] d;
      logic [2:0] di;
      model_reset();
      do_reset();

      // Single encrypt/decrypt round trip on slot 0
      run_req(1, 8'h5A, 0, 0, 0, 0);
      run_req(0, 0, 1, 8'h5A ^ m_pad[0], 3'd0, 0);

      // Fill all slots, blocked encrypt, free slot 0, wrapped encrypt
      do_reset();
      for (int i = 0; i < 8; i++) run_req(1, 8'($urandom), 0, 0, 0, 0);
      run_req(1, 8'hC3, 0, 0, 0, 0);
      run_req(0, 0, 1, m_pad[0] ^ 8'h33, 3'd0, 0);
      run_req(1, 8'hC3, 0, 0, 0, 0);

      // Decrypt of an unused slot takes the error path
      run_req(0, 0, 1, m_pad[3] ^ 8'h11, 3'd3, 0);
      run_req(0, 0, 1, 8'h77, 3'd3, 0);

      // Simultaneous requests alternate starting with encrypt
      do_reset();
      for (int i = 0; i < 4; i++) run_req(1, 8'($urandom), 1, 8'h99, 3'(i), 0);

      // Result back-pressure, then an engine index mismatch
      run_req(1, 8'h42, 0, 0, 0, 5);
      idx_fault = 1;
      run_req(1, 8'h24, 0, 0, 0, 0);
      idx_fault = 0;

      // Reset while the engine is being issued
      @(negedge clk);
      enc_valid = 1; enc_data = 8'hEE;
      @(posedge clk); #1;
      enc_valid = 0;
      check("issue_ena", eng_ena, 1);
      rst_n = 0;
      @(posedge clk); #1;
      check_idle_zero("mid_reset");
      rst_n = 1;
      model_reset();
      run_req(1, 8'h10, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 60; i++) begin
         di = 3'($urandom_range(0, 7));
         d = ($urandom_range(0, 3) != 0) ? (m_pad[di] ^ 8'($urandom)) : 8'($urandom);
         run_req(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), d, di,
                 ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0);
      end

`ifdef OTP_STATS_EN
      check("stat_enc", stat_enc, m_se);
      check("stat_dec", stat_dec, m_sd);
      check("stat_err", stat_err, m_sx);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
